// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizes and read-sequencer state encoding for the
//               16 x 8-bit register file and its dump reader.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_WORD_SIZE  = 8;
  localparam int RF_NUM_REG    = 16;
  localparam int RF_INDEX_SIZE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader_if
// Description : Valid/ready output stream carrying register words and indices.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_reader_if
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE  = RF_WORD_SIZE,
  parameter int INDEX_SIZE = RF_INDEX_SIZE
);

  logic [WORD_SIZE-1:0]  out_data;
  logic [INDEX_SIZE-1:0] out_index;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks the register file read port (one register or a full
//               sweep) and streams each word with its index.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int WORD_SIZE  = RF_WORD_SIZE,
  parameter int NUM_REG    = RF_NUM_REG,
  parameter int INDEX_SIZE = RF_INDEX_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  single,
  input  logic [INDEX_SIZE-1:0] sel_addr,
  output logic                  busy,
  output logic [INDEX_SIZE-1:0] rf_read_address,
  input  logic [WORD_SIZE-1:0]  rf_read_data,
  regfile_dump_reader_if.master out,
  output logic                  done
);

  localparam logic [INDEX_SIZE-1:0] c_last_index = INDEX_SIZE'(NUM_REG - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [INDEX_SIZE-1:0] r_cur_addr;
  logic [INDEX_SIZE-1:0] r_end_addr;
  logic [WORD_SIZE-1:0]  r_out_data;
  logic [INDEX_SIZE-1:0] r_out_index;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_at_end;
  logic                  w_accept;

  assign w_at_end = (r_cur_addr == r_end_addr);
  assign w_accept = r_out_valid && out.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_FETCH;
      ST_FETCH: w_next_state = ST_HOLD;
      ST_HOLD:  if (w_accept) w_next_state = w_at_end ? ST_DONE : ST_FETCH;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // busy/done are derived from the next state so they stay registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_end_addr  <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (w_next_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cur_addr <= single ? sel_addr : '0;
            r_end_addr <= single ? sel_addr : c_last_index;
          end
        end
        ST_FETCH: begin
          r_out_data  <= rf_read_data;
          r_out_index <= r_cur_addr;
          r_out_valid <= 1'b1;
          r_out_last  <= w_at_end;
        end
        ST_HOLD: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (!w_at_end) r_cur_addr <= r_cur_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign rf_read_address = r_cur_addr;
  assign out.out_data    = r_out_data;
  assign out.out_index   = r_out_index;
  assign out.out_valid   = r_out_valid;
  assign out.out_last    = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Directed self-checking bench for the register file dump reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       single;
  logic [3:0] sel_addr;
  logic       busy;
  logic [3:0] rf_read_address;
  logic [7:0] rf_read_data;
  logic       done;
  logic [7:0] regs [16];

  int checks = 0;
  int errors = 0;

  regfile_dump_reader_if #(.WORD_SIZE(8), .INDEX_SIZE(4)) dif ();

  regfile_dump_reader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .single          (single),
    .sel_addr        (sel_addr),
    .busy            (busy),
    .rf_read_address (rf_read_address),
    .rf_read_data    (rf_read_data),
    .out             (dif),
    .done            (done)
  );

  assign rf_read_data = regs[rf_read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) regs[i] = 8'hA0 + 8'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (rf_read_address !== 4'd0) begin errors++; $display("FAIL reset_addr got %0h want 0", rf_read_address); end
    checks++; if (dif.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", dif.out_data); end
    checks++; if (dif.out_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0h want 0", dif.out_index); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dif.out_valid); end
    checks++; if (dif.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", dif.out_last); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_dump();
    int nwords;
    logic [7:0] exp;
    preload();
    nwords = 0;
    dif.out_ready = 1'b1;
    single = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (c == 1) begin
        checks++; if (busy !== 1'b1 || dif.out_valid !== 1'b0) begin errors++; $display("FAIL full_fetch busy=%0b valid=%0b want 1/0", busy, dif.out_valid); end
      end
      if (c == 2) begin
        checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL full_first_valid got %0b want 1", dif.out_valid); end
      end
      if (dif.out_valid === 1'b1 && dif.out_ready) begin
        exp = 8'hA0 + 8'(nwords);
        checks++; if (dif.out_index !== 4'(nwords)) begin errors++; $display("FAIL full_index got %0d want %0d", dif.out_index, nwords); end
        checks++; if (dif.out_data !== exp) begin errors++; $display("FAIL full_data got %0h want %0h", dif.out_data, exp); end
        checks++; if (dif.out_last !== (nwords == 15)) begin errors++; $display("FAIL full_last idx %0d got %0b", nwords, dif.out_last); end
        nwords++;
      end
      checks++; if (done !== (c == 33)) begin errors++; $display("FAIL full_done cycle %0d got %0b want %0b", c, done, (c == 33)); end
      if (c == 33) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_done got %0b want 1", busy); end
      end
      if (c == 34) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got %0b want 0", busy); end
      end
      tick();
    end
    checks++; if (nwords != 16) begin errors++; $display("FAIL full_count got %0d want 16", nwords); end
  endtask

  task automatic test_single();
    regs[9] = 8'h5C;
    dif.out_ready = 1'b1;
    single = 1'b1;
    sel_addr = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", dif.out_valid); end
    checks++; if (dif.out_index !== 4'd9) begin errors++; $display("FAIL single_index got %0d want 9", dif.out_index); end
    checks++; if (dif.out_data !== 8'h5C) begin errors++; $display("FAIL single_data got %0h want 5c", dif.out_data); end
    checks++; if (dif.out_last !== 1'b1) begin errors++; $display("FAIL single_last got %0b want 1", dif.out_last); end
    tick();
    checks++; if (done !== 1'b1 || dif.out_valid !== 1'b0) begin errors++; $display("FAIL single_done done=%0b valid=%0b want 1/0", done, dif.out_valid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle done=%0b busy=%0b want 0/0", done, busy); end
    single = 1'b0;
    sel_addr = 4'd0;
    regs[9] = 8'hA9;
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic [3:0] idx;
    int w;
    preload();
    dif.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w = 0;
      while (dif.out_valid !== 1'b1 && w < 10) begin tick(); w++; end
      checks++;
      if (dif.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_timeout word %0d valid=%0b want 1", k, dif.out_valid);
        break;
      end
      d = dif.out_data;
      idx = dif.out_index;
      checks++; if (idx !== 4'(k)) begin errors++; $display("FAIL bp_index got %0d want %0d", idx, k); end
      checks++; if (d !== 8'hA0 + 8'(k)) begin errors++; $display("FAIL bp_data got %0h want %0h", d, 8'hA0 + 8'(k)); end
      for (int s = 0; s < 5; s++) begin
        tick();
        checks++;
        if (dif.out_valid !== 1'b1 || dif.out_data !== d || dif.out_index !== idx) begin
          errors++; $display("FAIL bp_stable word %0d valid=%0b data=%0h idx=%0d want 1/%0h/%0d", k, dif.out_valid, dif.out_data, dif.out_index, d, idx);
        end
      end
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop word %0d valid=%0b want 0", k, dif.out_valid); end
      if (k == 15) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %0b want 1", done); end
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL bp_idle busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_back_to_back_start();
    int nwords;
    int ndone;
    nwords = 0;
    ndone = 0;
    preload();
    dif.out_ready = 1'b1;
    single = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin start = 1'b1; single = 1'b1; sel_addr = 4'd3; end
      if (c == 11) begin start = 1'b0; single = 1'b0; sel_addr = 4'd0; end
      if (dif.out_valid === 1'b1) begin
        checks++; if (dif.out_index !== 4'(nwords)) begin errors++; $display("FAIL busy_start_index got %0d want %0d", dif.out_index, nwords); end
        nwords++;
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++; if (nwords != 16) begin errors++; $display("FAIL busy_start_count got %0d want 16", nwords); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done got %0d want 1", ndone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_dump();
    int w;
    int ndone;
    preload();
    dif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!(dif.out_valid === 1'b1 && dif.out_index === 4'd6) && w < 40) begin tick(); w++; end
    dif.out_ready = 1'b0;
    checks++; if (dif.out_valid !== 1'b1 || dif.out_index !== 4'd6) begin errors++; $display("FAIL rst_mid_reach valid=%0b idx=%0d want 1/6", dif.out_valid, dif.out_index); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || rf_read_address !== 4'd0 || dif.out_data !== 8'h00 || dif.out_index !== 4'd0 ||
        dif.out_valid !== 1'b0 || dif.out_last !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs busy=%0b addr=%0h data=%0h idx=%0h valid=%0b last=%0b done=%0b want all 0",
                         busy, rf_read_address, dif.out_data, dif.out_index, dif.out_valid, dif.out_last, done);
    end
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", ndone); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (dif.out_valid !== 1'b1 || dif.out_index !== 4'd0 || dif.out_data !== 8'hA0) begin
      errors++; $display("FAIL rst_mid_restart valid=%0b idx=%0d data=%0h want 1/0/a0", dif.out_valid, dif.out_index, dif.out_data);
    end
    dif.out_ready = 1'b1;
    w = 0;
    while (busy === 1'b1 && w < 40) begin tick(); w++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_finish busy=%0b want 0", busy); end
  endtask

  task automatic test_concurrent_write();
    int nwords;
    int hold;
    logic stalled;
    logic [7:0] exp;
    preload();
    nwords = 0;
    hold = 0;
    stalled = 1'b0;
    dif.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (dif.out_valid === 1'b1 && !stalled && dif.out_index === 4'd4) begin
        dif.out_ready = 1'b0;
        regs[10] = 8'hFF;
        stalled = 1'b1;
        hold = 3;
      end else if (!dif.out_ready && hold > 0) begin
        hold--;
        if (hold == 0) dif.out_ready = 1'b1;
      end
      if (dif.out_valid === 1'b1 && dif.out_ready) begin
        exp = (nwords == 10) ? 8'hFF : 8'hA0 + 8'(nwords);
        checks++; if (dif.out_index !== 4'(nwords) || dif.out_data !== exp) begin
          errors++; $display("FAIL cw_word idx=%0d data=%0h want %0d/%0h", dif.out_index, dif.out_data, nwords, exp);
        end
        nwords++;
      end
      tick();
    end
    checks++; if (nwords != 16) begin errors++; $display("FAIL cw_count got %0d want 16", nwords); end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    single = 1'b0;
    sel_addr = 4'd0;
    dif.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    test_reset();
    test_full_dump();
    test_single();
    test_backpressure();
    test_back_to_back_start();
    test_reset_mid_dump();
    test_concurrent_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
